// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path:
// FSM states, ALU op codes, mux selects and one-hot instruction indices.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    // Coarse instruction class, used by the FSM to choose its path
    typedef enum logic [3:0] {
        C_R_ALU = 4'd0,
        C_I_ALU = 4'd1,
        C_LOAD  = 4'd2,
        C_STORE = 4'd3,
        C_BEQ   = 4'd4,
        C_BNE   = 4'd5,
        C_J     = 4'd6,
        C_JR    = 4'd7,
        C_JAL   = 4'd8
    } class_e;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic ASEL_RS    = 1'b0;
    localparam logic ASEL_SHAMT = 1'b1;
    localparam logic BSEL_RT    = 1'b0;
    localparam logic BSEL_IMM   = 1'b1;

    localparam logic [1:0] RF_DST_RT = 2'd0;
    localparam logic [1:0] RF_DST_RD = 2'd1;
    localparam logic [1:0] RF_DST_31 = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_RS     = 2'd3;

    localparam int IDX_ADD   = 0;
    localparam int IDX_ADDU  = 1;
    localparam int IDX_SUB   = 2;
    localparam int IDX_SUBU  = 3;
    localparam int IDX_AND   = 4;
    localparam int IDX_OR    = 5;
    localparam int IDX_XOR   = 6;
    localparam int IDX_NOR   = 7;
    localparam int IDX_SLT   = 8;
    localparam int IDX_SLTU  = 9;
    localparam int IDX_SLL   = 10;
    localparam int IDX_SRL   = 11;
    localparam int IDX_SRA   = 12;
    localparam int IDX_SLLV  = 13;
    localparam int IDX_SRLV  = 14;
    localparam int IDX_SRAV  = 15;
    localparam int IDX_JR    = 16;
    localparam int IDX_ADDI  = 17;
    localparam int IDX_ADDIU = 18;
    localparam int IDX_ANDI  = 19;
    localparam int IDX_ORI   = 20;
    localparam int IDX_XORI  = 21;
    localparam int IDX_LW    = 22;
    localparam int IDX_SW    = 23;
    localparam int IDX_BEQ   = 24;
    localparam int IDX_BNE   = 25;
    localparam int IDX_SLTI  = 26;
    localparam int IDX_SLTIU = 27;
    localparam int IDX_LUI   = 28;
    localparam int IDX_J     = 29;
    localparam int IDX_JAL   = 30;

    // Static per-instruction control word
    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_a_sel;
        logic       alu_b_sel;
        logic       ext_sign;
        logic [1:0] rf_dst_sel;
        logic [1:0] wb_sel;
        class_e     cls;
    } ctrl_word_t;

    // A code is usable only if exactly one defined bit is set
    function automatic logic code_bad(input logic [31:0] code);
        return ($countones(code) != 1) || code[31];
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_table.sv
// Combinational one-hot code to static control word lookup.
// Illegal codes fall through to an all-zero word; the FSM never uses it.
module ctrl_table
    import mips_ctrl_pkg::*;
(
    input  logic [30:0] code_i,
    output ctrl_word_t  ctrl_o
);

    // Register-register ALU entry with rd destination
    function automatic ctrl_word_t r_op(input logic [3:0] op, input logic a);
        ctrl_word_t w;
        w            = '0;
        w.alu_op     = op;
        w.alu_a_sel  = a;
        w.alu_b_sel  = BSEL_RT;
        w.rf_dst_sel = RF_DST_RD;
        w.wb_sel     = WB_ALU;
        w.cls        = C_R_ALU;
        return w;
    endfunction

    // Register-immediate ALU entry with rt destination
    function automatic ctrl_word_t i_op(input logic [3:0] op, input logic sx);
        ctrl_word_t w;
        w            = '0;
        w.alu_op     = op;
        w.alu_b_sel  = BSEL_IMM;
        w.ext_sign   = sx;
        w.rf_dst_sel = RF_DST_RT;
        w.wb_sel     = WB_ALU;
        w.cls        = C_I_ALU;
        return w;
    endfunction

    // First set bit wins; multi-hot codes are trapped in DECODE anyway
    always_comb begin
        ctrl_o = '0;
        case (1'b1)
            code_i[IDX_ADD]:   ctrl_o = r_op(ALU_ADD, ASEL_RS);
            code_i[IDX_ADDU]:  ctrl_o = r_op(ALU_ADD, ASEL_RS);
            code_i[IDX_SUB]:   ctrl_o = r_op(ALU_SUB, ASEL_RS);
            code_i[IDX_SUBU]:  ctrl_o = r_op(ALU_SUB, ASEL_RS);
            code_i[IDX_AND]:   ctrl_o = r_op(ALU_AND, ASEL_RS);
            code_i[IDX_OR]:    ctrl_o = r_op(ALU_OR, ASEL_RS);
            code_i[IDX_XOR]:   ctrl_o = r_op(ALU_XOR, ASEL_RS);
            code_i[IDX_NOR]:   ctrl_o = r_op(ALU_NOR, ASEL_RS);
            code_i[IDX_SLT]:   ctrl_o = r_op(ALU_SLT, ASEL_RS);
            code_i[IDX_SLTU]:  ctrl_o = r_op(ALU_SLTU, ASEL_RS);
            code_i[IDX_SLL]:   ctrl_o = r_op(ALU_SLL, ASEL_SHAMT);
            code_i[IDX_SRL]:   ctrl_o = r_op(ALU_SRL, ASEL_SHAMT);
            code_i[IDX_SRA]:   ctrl_o = r_op(ALU_SRA, ASEL_SHAMT);
            code_i[IDX_SLLV]:  ctrl_o = r_op(ALU_SLL, ASEL_RS);
            code_i[IDX_SRLV]:  ctrl_o = r_op(ALU_SRL, ASEL_RS);
            code_i[IDX_SRAV]:  ctrl_o = r_op(ALU_SRA, ASEL_RS);
            code_i[IDX_JR]: begin
                ctrl_o.alu_op = ALU_ADD;
                ctrl_o.cls    = C_JR;
            end
            code_i[IDX_ADDI]:  ctrl_o = i_op(ALU_ADD, 1'b1);
            code_i[IDX_ADDIU]: ctrl_o = i_op(ALU_ADD, 1'b1);
            code_i[IDX_ANDI]:  ctrl_o = i_op(ALU_AND, 1'b0);
            code_i[IDX_ORI]:   ctrl_o = i_op(ALU_OR, 1'b0);
            code_i[IDX_XORI]:  ctrl_o = i_op(ALU_XOR, 1'b0);
            code_i[IDX_LW]: begin
                ctrl_o        = i_op(ALU_ADD, 1'b1);
                ctrl_o.wb_sel = WB_MEM;
                ctrl_o.cls    = C_LOAD;
            end
            code_i[IDX_SW]: begin
                ctrl_o     = i_op(ALU_ADD, 1'b1);
                ctrl_o.cls = C_STORE;
            end
            code_i[IDX_BEQ]: begin
                ctrl_o.alu_op   = ALU_SUB;
                ctrl_o.ext_sign = 1'b1;
                ctrl_o.cls      = C_BEQ;
            end
            code_i[IDX_BNE]: begin
                ctrl_o.alu_op   = ALU_SUB;
                ctrl_o.ext_sign = 1'b1;
                ctrl_o.cls      = C_BNE;
            end
            code_i[IDX_SLTI]:  ctrl_o = i_op(ALU_SLT, 1'b1);
            code_i[IDX_SLTIU]: ctrl_o = i_op(ALU_SLTU, 1'b1);
            code_i[IDX_LUI]:   ctrl_o = i_op(ALU_LUI, 1'b0);
            code_i[IDX_J]: begin
                ctrl_o.cls = C_J;
            end
            code_i[IDX_JAL]: begin
                ctrl_o.rf_dst_sel = RF_DST_31;
                ctrl_o.wb_sel     = WB_PC;
                ctrl_o.cls        = C_JAL;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS core.
// Sequences FETCH/DECODE/EXEC/MEM/WB and gates the static control word by state.
module multi_cycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter logic [2:0] RESET_STATE = 3'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] code,
    input  logic        zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic [2:0]  state,
    output logic        pc_we,
    output logic        ir_we,
    output logic        rf_we,
    output logic        dmem_re,
    output logic        dmem_we,
    output logic [3:0]  alu_op,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic        ext_sign,
    output logic [1:0]  rf_dst_sel,
    output logic [1:0]  wb_sel,
    output logic [1:0]  pc_sel,
    output logic        illegal
);

    state_e     state_q;
    state_e     state_d;
    ctrl_word_t cw;

    ctrl_table u_table (
        .code_i (code[30:0]),
        .ctrl_o (cw)
    );

    assign state = state_q;

    // State register; reset returns to FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= state_e'(RESET_STATE);
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-gated strobes/selects
    always_comb begin
        state_d    = state_q;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        rf_we      = 1'b0;
        dmem_re    = 1'b0;
        dmem_we    = 1'b0;
        illegal    = 1'b0;
        alu_op     = ALU_ADD;
        alu_a_sel  = ASEL_RS;
        alu_b_sel  = BSEL_RT;
        ext_sign   = 1'b0;
        rf_dst_sel = RF_DST_RT;
        wb_sel     = WB_ALU;
        pc_sel     = PC_PLUS4;

        if (rst) begin
            state_d = S_FETCH;
        end else begin
            // ALU controls stay stable from EXEC through WB
            if (state_q == S_EXEC || state_q == S_MEM ||
                state_q == S_WB) begin
                alu_op     = cw.alu_op;
                alu_a_sel  = cw.alu_a_sel;
                alu_b_sel  = cw.alu_b_sel;
                ext_sign   = cw.ext_sign;
                rf_dst_sel = cw.rf_dst_sel;
                wb_sel     = cw.wb_sel;
            end

            unique case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (code_bad(code)) begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    unique case (cw.cls)
                        C_BEQ: begin
                            pc_we   = zero;
                            pc_sel  = PC_BRANCH;
                            state_d = S_FETCH;
                        end
                        C_BNE: begin
                            pc_we   = ~zero;
                            pc_sel  = PC_BRANCH;
                            state_d = S_FETCH;
                        end
                        C_J: begin
                            pc_we   = 1'b1;
                            pc_sel  = PC_JUMP;
                            state_d = S_FETCH;
                        end
                        C_JR: begin
                            pc_we   = 1'b1;
                            pc_sel  = PC_RS;
                            state_d = S_FETCH;
                        end
                        // RF captures the current PC, which is already PC+4
                        C_JAL: begin
                            pc_we   = 1'b1;
                            pc_sel  = PC_JUMP;
                            rf_we   = 1'b1;
                            state_d = S_FETCH;
                        end
                        C_LOAD, C_STORE: state_d = S_MEM;
                        default:         state_d = S_WB;
                    endcase
                end
                S_MEM: begin
                    if (cw.cls == C_LOAD) begin
                        dmem_re = 1'b1;
                    end else begin
                        dmem_we = 1'b1;
                    end
                    if (dmem_ready) begin
                        state_d = (cw.cls == C_LOAD) ? S_WB : S_FETCH;
                    end
                end
                S_WB: begin
                    rf_we   = 1'b1;
                    state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl.
// Inputs change 1ns after a rising edge; outputs are sampled 1ns later.
module tb_multi_cycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] code;
    logic        zero;
    logic        imem_ready;
    logic        dmem_ready;
    logic [2:0]  state;
    logic        pc_we, ir_we, rf_we, dmem_re, dmem_we;
    logic [3:0]  alu_op;
    logic        alu_a_sel, alu_b_sel, ext_sign;
    logic [1:0]  rf_dst_sel, wb_sel, pc_sel;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    multi_cycle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .code       (code),
        .zero       (zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .state      (state),
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .rf_we      (rf_we),
        .dmem_re    (dmem_re),
        .dmem_we    (dmem_we),
        .alu_op     (alu_op),
        .alu_a_sel  (alu_a_sel),
        .alu_b_sel  (alu_b_sel),
        .ext_sign   (ext_sign),
        .rf_dst_sel (rf_dst_sel),
        .wb_sel     (wb_sel),
        .pc_sel     (pc_sel),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // {pc_we, ir_we, rf_we, dmem_re, dmem_we, illegal}
    function automatic logic [5:0] strobes();
        return {pc_we, ir_we, rf_we, dmem_re, dmem_we, illegal};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b0;
        code = 32'h0080_0000; zero = 1'b0;
        tick(); #1;
        checks++;
        if (state !== 3'd0 || strobes() !== 6'b0) begin
            errors++;
            $display("FAIL reset_state: state=%0d strobes=%b exp 0/000000", state, strobes());
        end
        rst = 1'b0; #1;
        checks++;
        if (strobes() !== 6'b110000) begin
            errors++;
            $display("FAIL fetch_strobes: got %b exp 110000", strobes());
        end
        tick(); tick(); tick(); #1;
        checks++;
        if (state !== 3'd3 || dmem_we !== 1'b1) begin
            errors++;
            $display("FAIL sw_mem: state=%0d dmem_we=%b exp 3/1", state, dmem_we);
        end
        rst = 1'b1; #1;
        checks++;
        if (strobes() !== 6'b0) begin
            errors++;
            $display("FAIL rst_in_mem: strobes=%b exp 000000", strobes());
        end
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            checks++;
            if (state !== 3'd0 || strobes() !== 6'b0) begin
                errors++;
                $display("FAIL rst_hold%0d: state=%0d strobes=%b exp 0/000000", i, state, strobes());
            end
        end
        rst = 1'b0; imem_ready = 1'b0;
        tick(); #1;
        checks++;
        if (state !== 3'd0 || strobes() !== 6'b0) begin
            errors++;
            $display("FAIL post_rst: state=%0d strobes=%b exp 0/000000", state, strobes());
        end
        imem_ready = 1'b1;
    endtask

    task automatic test_add();
        logic [2:0] exp_st [5];
        logic [5:0] exp_sb [5];
        int pcw;
        exp_st = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
        exp_sb = '{6'b110000, 6'b000000, 6'b000000, 6'b001000, 6'b110000};
        code = 32'h1; imem_ready = 1'b1; dmem_ready = 1'b1;
        pcw = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (i < 4) pcw += int'(pc_we);
            checks++;
            if (state !== exp_st[i] || strobes() !== exp_sb[i]) begin
                errors++;
                $display("FAIL add_cyc%0d: state=%0d strobes=%b exp %0d/%b", i, state, strobes(), exp_st[i], exp_sb[i]);
            end
            if (i == 3) begin
                checks++;
                if ({rf_dst_sel, alu_op, wb_sel} !== {2'd1, 4'd0, 2'd0}) begin
                    errors++;
                    $display("FAIL add_wb: dst=%0d op=%0d wb=%0d exp 1/0/0", rf_dst_sel, alu_op, wb_sel);
                end
            end
            if (i < 4) tick();
        end
        checks++;
        if (pcw !== 1) begin
            errors++;
            $display("FAIL add_pc_we_count: got %0d exp 1", pcw);
        end
    endtask

    task automatic test_lw_wait();
        int n, re_cnt, mem_cnt;
        logic wb_ok;
        code = 32'h1 << 22; imem_ready = 1'b1;
        n = 0; re_cnt = 0; mem_cnt = 0; wb_ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            dmem_ready = (state == 3'd3) && (mem_cnt == 2);
            #1;
            if (dmem_re) re_cnt++;
            if (state == 3'd3) mem_cnt++;
            if (state == 3'd4)
                wb_ok = (wb_sel === 2'd1) && (rf_we === 1'b1) && (rf_dst_sel === 2'd0);
            tick();
            n++;
            if (state == 3'd0) break;
        end
        dmem_ready = 1'b1;
        checks++;
        if (n !== 7) begin
            errors++;
            $display("FAIL lw_cycles: got %0d exp 7", n);
        end
        checks++;
        if (re_cnt !== 3) begin
            errors++;
            $display("FAIL lw_dmem_re: got %0d exp 3", re_cnt);
        end
        checks++;
        if (wb_ok !== 1'b1) begin
            errors++;
            $display("FAIL lw_wb: got %b exp 1", wb_ok);
        end
    endtask

    task automatic test_branch();
        logic [31:0] codes [4];
        logic        zs    [4];
        logic        pcw   [4];
        codes = '{32'h1 << 24, 32'h1 << 24, 32'h1 << 25, 32'h1 << 25};
        zs    = '{1'b1, 1'b0, 1'b1, 1'b0};
        pcw   = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            code = codes[i]; zero = zs[i];
            tick(); tick(); #1;
            checks++;
            if ({state, pc_we, pc_sel, alu_op} !== {3'd2, pcw[i], 2'd1, 4'd1}) begin
                errors++;
                $display("FAIL branch%0d: st=%0d pc_we=%b sel=%0d op=%0d exp 2/%b/1/1", i, state, pc_we, pc_sel, alu_op, pcw[i]);
            end
            tick(); #1;
            checks++;
            if (state !== 3'd0) begin
                errors++;
                $display("FAIL branch%0d_next: state=%0d exp 0", i, state);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jal();
        code = 32'h1 << 30;
        tick(); tick(); #1;
        checks++;
        if ({pc_we, pc_sel, rf_we, rf_dst_sel, wb_sel, dmem_we} !== {1'b1, 2'd2, 1'b1, 2'd2, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL jal_exec: pc_we=%b sel=%0d rf_we=%b dst=%0d wb=%0d", pc_we, pc_sel, rf_we, rf_dst_sel, wb_sel);
        end
        tick(); #1;
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL jal_next: state=%0d exp 0", state);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bad [3];
        bad = '{32'h0, 32'h3, 32'h8000_0000};
        for (int i = 0; i < 3; i++) begin
            code = bad[i];
            tick(); #1;
            checks++;
            if ({state, illegal, rf_we, dmem_we} !== {3'd1, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL illegal%0d: st=%0d ill=%b rf_we=%b dmem_we=%b exp 1/1/0/0", i, state, illegal, rf_we, dmem_we);
            end
            tick(); #1;
            checks++;
            if (state !== 3'd0 || illegal !== 1'b0) begin
                errors++;
                $display("FAIL illegal%0d_next: st=%0d ill=%b exp 0/0", i, state, illegal);
            end
        end
    endtask

    task automatic test_imm_shift();
        code = 32'h1 << 19;
        tick(); tick(); #1;
        checks++;
        if ({ext_sign, alu_b_sel, alu_op} !== {1'b0, 1'b1, 4'd2}) begin
            errors++;
            $display("FAIL andi_exec: ext=%b bsel=%b op=%0d exp 0/1/2", ext_sign, alu_b_sel, alu_op);
        end
        tick(); #1;
        checks++;
        if ({state, rf_we, rf_dst_sel} !== {3'd4, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL andi_wb: st=%0d rf_we=%b dst=%0d exp 4/1/0", state, rf_we, rf_dst_sel);
        end
        tick();
        code = 32'h1 << 17;
        tick(); tick(); #1;
        checks++;
        if ({ext_sign, alu_b_sel, alu_op} !== {1'b1, 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL addi_exec: ext=%b bsel=%b op=%0d exp 1/1/0", ext_sign, alu_b_sel, alu_op);
        end
        tick(); tick();
        code = 32'h1 << 10;
        tick(); tick(); #1;
        checks++;
        if ({alu_a_sel, alu_op} !== {1'b1, 4'd8}) begin
            errors++;
            $display("FAIL sll_exec: asel=%b op=%0d exp 1/8", alu_a_sel, alu_op);
        end
        tick(); tick();
    endtask

    task automatic test_fetch_wait();
        code = 32'h1 << 16; imem_ready = 1'b0;
        tick(); tick(); #1;
        checks++;
        if (state !== 3'd0 || strobes() !== 6'b0) begin
            errors++;
            $display("FAIL fetch_wait: st=%0d strobes=%b exp 0/000000", state, strobes());
        end
        imem_ready = 1'b1;
        tick(); tick(); #1;
        checks++;
        if ({state, pc_we, pc_sel} !== {3'd2, 1'b1, 2'd3}) begin
            errors++;
            $display("FAIL jr_exec: st=%0d pc_we=%b sel=%0d exp 2/1/3", state, pc_we, pc_sel);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        code = 32'h1 << 23; dmem_ready = 1'b1; imem_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n++;
            if (state == 3'd0) break;
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL sw_latency: got %0d exp 4", n);
        end
    endtask

    initial begin
        rst = 1'b1; code = '0; zero = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        test_reset();
        test_add();
        test_lw_wait();
        test_branch();
        test_jal();
        test_illegal();
        test_imm_shift();
        test_fetch_wait();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
